conv_frame_sched: RTL and testbench
===================================

CONV_FRAME_SCHED -- requirements
Module: conv_frame_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 64: maximum image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 64: maximum image height in pixels.
REQ-003 SHALL have parameter MAX_KERNEL, default 3: maximum kernel dimension, matching the convolution datapath.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port n_rst  in  1  asynchronous, active-low reset.
REQ-006 Port frame_start  in  1  frame-start request, sampled only in IDLE.
REQ-007 Port cfg_last_x  in  $clog2(IMG_W)  last column index (width-1).
REQ-008 Port cfg_last_y  in  $clog2(IMG_H)  last row index (height-1).
REQ-009 Port cfg_ksize  in  $clog2(MAX_KERNEL)  kernel size code passed to the datapath.
REQ-010 Port win_req / win_ready  out/in  1/1  window-load handshake to the line buffer.
REQ-011 Port win_x, win_y  out  $clog2(IMG_W), $clog2(IMG_H)  window centre requested.
REQ-012 Port ck_start  out  1  datapath start, held high for exactly one cycle per pixel.
REQ-013 Port ck_done  in  1  datapath completion pulse.
REQ-014 Port ck_pixel  in  8  datapath result.
REQ-015 Port ck_clear / ck_clear_flag  out/in  1/1  accumulator-clear request and its acknowledge.
REQ-016 Port ck_ksize  out  $clog2(MAX_KERNEL)  latched kernel size.
REQ-017 Port pix_valid / pix_ready  out/in  1/1  output stream handshake.
REQ-018 Port pix_data  out  8  output pixel.
REQ-019 Port pix_x, pix_y  out  coordinates of pix_data.
REQ-020 Port busy, frame_done  out  1/1  frame in progress; one-cycle end-of-frame pulse.

Function
REQ-021 SHALL implement states IDLE, LOAD, START, WAIT, OUT, CLEAR and NEXT.
REQ-022 IDLE: on frame_start=1, SHALL latch cfg_last_x, cfg_last_y and cfg_ksize, set x=y=0, and go to LOAD; busy=1 in every state except IDLE.
REQ-023 LOAD: SHALL assert win_req with win_x=x, win_y=y and leave both stable until the cycle win_ready=1; it then goes to START.
REQ-024 START: SHALL assert ck_start for one cycle, then go to WAIT.
REQ-025 WAIT: when ck_done=1, SHALL capture ck_pixel into pix_data in that cycle's edge and go to OUT; ck_done seen in any other state is ignored.
REQ-026 OUT: SHALL hold pix_valid=1 and keep pix_data/pix_x/pix_y stable until pix_ready=1; the transfer happens in that cycle, and the block then goes to CLEAR.
REQ-027 CLEAR: SHALL hold ck_clear=1 until ck_clear_flag=1, then go to NEXT.
REQ-028 NEXT, one cycle: if x<last_x, x increments; otherwise x=0, and y increments if y<last_y; otherwise the block pulses frame_done and goes to IDLE. In all other cases it goes to LOAD.
REQ-029 Minimum per-pixel latency with all handshakes ready SHALL be 5 cycles plus the datapath latency.
REQ-030 frame_start while busy SHALL be ignored; the latched configuration SHALL NOT change mid-frame.
REQ-031 cfg_last_x=0 and/or cfg_last_y=0 SHALL produce a single-column and/or single-row frame, with no wrap error.
REQ-032 win_ready, pix_ready and ck_clear_flag asserted outside their own states SHALL be ignored.

Reset
REQ-033 n_rst=0 SHALL immediately force IDLE with x=y=0, all outputs 0 (pix_data=0, ck_ksize=0), even mid-frame; no frame_done is produced.

Configuration
REQ-034 With SCHED_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits): a saturating count of cycles with pix_valid=1 and pix_ready=0, cleared on frame start and on reset. Without the macro, the port and its logic SHALL be absent.

Verification
REQ-035 last_x=1, last_y=1, all handshakes tied ready, datapath done 3 cycles after start -> 4 pixels out in order (0,0),(1,0),(0,1),(1,1); then frame_done exactly once.
REQ-036 pix_ready held low for 10 cycles in OUT -> pix_valid, pix_data and coordinates stable throughout; with SCHED_STALL_CNT_EN, stall_cnt=10.
REQ-037 frame_start pulsed again mid-frame with cfg_last_x changed to 5 -> ignored; the frame completes with the original dimensions.
REQ-038 n_rst asserted during WAIT -> all outputs 0 asynchronously; after release, state is IDLE and no frame_done occurs.
REQ-039 last_x=0, last_y=0 -> exactly one ck_start, one pixel (0,0) with pix_data=ck_pixel (0xA5), then frame_done.
REQ-040 ck_clear_flag delayed 4 cycles -> ck_clear held 4 cycles; no win_req until the acknowledge arrives.

Source files
------------

// File: rtl/conv_frame_sched_if.sv
// Output pixel stream bundle for conv_frame_sched.
// Master drives pixel and coordinates, slave returns pix_ready.
interface conv_frame_sched_if #(
    parameter int XW = 6,
    parameter int YW = 6
);
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y,
        output pix_ready
    );
endinterface

// File: rtl/conv_frame_sched.sv
// Frame scheduler: walks a convolution window over an image, one pixel at a time.
// Optional SCHED_STALL_CNT_EN adds a saturating output-stall counter port.
module conv_frame_sched #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int MAX_KERNEL = 3
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          frame_start,
    input  logic [$clog2(IMG_W)-1:0]      cfg_last_x,
    input  logic [$clog2(IMG_H)-1:0]      cfg_last_y,
    input  logic [$clog2(MAX_KERNEL)-1:0] cfg_ksize,
    output logic                          win_req,
    input  logic                          win_ready,
    output logic [$clog2(IMG_W)-1:0]      win_x,
    output logic [$clog2(IMG_H)-1:0]      win_y,
    output logic                          ck_start,
    input  logic                          ck_done,
    input  logic [7:0]                    ck_pixel,
    output logic                          ck_clear,
    input  logic                          ck_clear_flag,
    output logic [$clog2(MAX_KERNEL)-1:0] ck_ksize,
    conv_frame_sched_if.master            pix,
    output logic                          busy,
    output logic                          frame_done
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_OUT,
        S_CLEAR,
        S_NEXT
    } state_t;

    state_t                   state;
    logic [$clog2(IMG_W)-1:0] x;
    logic [$clog2(IMG_H)-1:0] y;
    logic [$clog2(IMG_W)-1:0] last_x;
    logic [$clog2(IMG_H)-1:0] last_y;

    // Current window position doubles as the coordinate of the pixel in flight.
    assign win_x     = x;
    assign win_y     = y;
    assign pix.pix_x = x;
    assign pix.pix_y = y;

    // Frame walk FSM; every control output is a register set on state entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            last_x        <= '0;
            last_y        <= '0;
            ck_ksize      <= '0;
            win_req       <= 1'b0;
            ck_start      <= 1'b0;
            ck_clear      <= 1'b0;
            pix.pix_valid <= 1'b0;
            pix.pix_data  <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        last_x   <= cfg_last_x;
                        last_y   <= cfg_last_y;
                        ck_ksize <= cfg_ksize;
                        x        <= '0;
                        y        <= '0;
                        busy     <= 1'b1;
                        win_req  <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (win_ready) begin
                        win_req  <= 1'b0;
                        ck_start <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    ck_start <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (ck_done) begin
                        pix.pix_data  <= ck_pixel;
                        pix.pix_valid <= 1'b1;
                        state         <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        ck_clear      <= 1'b1;
                        state         <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (ck_clear_flag) begin
                        ck_clear <= 1'b0;
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (x < last_x) begin
                        x       <= x + 1'b1;
                        win_req <= 1'b1;
                        state   <= S_LOAD;
                    end else if (y < last_y) begin
                        x       <= '0;
                        y       <= y + 1'b1;
                        win_req <= 1'b1;
                        state   <= S_LOAD;
                    end else begin
                        x          <= '0;
                        y          <= '0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCHED_STALL_CNT_EN
    // Saturating count of cycles the output sink holds back a valid pixel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && frame_start) begin
            stall_cnt <= '0;
        end else if (pix.pix_valid && !pix.pix_ready &&
                     stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_frame_sched.sv
// Self-checking bench for conv_frame_sched with randomized handshake timing.
// Expected pixel order comes from a nested-loop raster model of the frame.
module tb_conv_frame_sched;

    logic       clk;
    logic       n_rst;
    logic       frame_start;
    logic [5:0] cfg_last_x;
    logic [5:0] cfg_last_y;
    logic [1:0] cfg_ksize;
    logic       win_req;
    logic       win_ready;
    logic [5:0] win_x;
    logic [5:0] win_y;
    logic       ck_start;
    logic       ck_done;
    logic [7:0] ck_pixel;
    logic       ck_clear;
    logic       ck_clear_flag;
    logic [1:0] ck_ksize;
    logic       busy;
    logic       frame_done;
`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv_frame_sched_if #(.XW(6), .YW(6)) pif ();

    conv_frame_sched dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .frame_start   (frame_start),
        .cfg_last_x    (cfg_last_x),
        .cfg_last_y    (cfg_last_y),
        .cfg_ksize     (cfg_ksize),
        .win_req       (win_req),
        .win_ready     (win_ready),
        .win_x         (win_x),
        .win_y         (win_y),
        .ck_start      (ck_start),
        .ck_done       (ck_done),
        .ck_pixel      (ck_pixel),
        .ck_clear      (ck_clear),
        .ck_clear_flag (ck_clear_flag),
        .ck_ksize      (ck_ksize),
        .pix           (pif),
        .busy          (busy),
        .frame_done    (frame_done)
`ifdef SCHED_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int win_delay = 0;
    int dp_lat = 3;
    int pix_delay = 0;
    int clr_delay = 0;
    bit noise = 0;
    bit force_pix = 0;

    int cyc = 0;
    int wcnt, pcnt, ccnt, dp_cnt;
    int obs_x[$];
    int obs_y[$];
    logic [7:0] obs_d[$];
    logic [7:0] dp_d[$];
    int start_cyc[$];
    int n_done, stab_bad, start_bad, win_in_clear, stall_obs;
    int clr_hi_cur, clr_hi_max;
    logic prev_start;
    logic [5:0] lw_x, lw_y, lp_x, lp_y;
    logic [7:0] lp_d;

    // Environment: line buffer, datapath, sink and clear-ack models plus monitors.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!n_rst) begin
                win_ready = 0;
                ck_done = 0;
                pif.pix_ready = 0;
                ck_clear_flag = 0;
                dp_cnt = 0;
                wcnt = 0;
                pcnt = 0;
                ccnt = 0;
                prev_start = 0;
                clr_hi_cur = 0;
            end else begin
                ck_done = 0;
                ck_pixel = 8'($urandom);
                if (dp_cnt > 0) begin
                    dp_cnt--;
                    if (dp_cnt == 0) begin
                        ck_done = 1;
                        ck_pixel = force_pix ? 8'hA5 : 8'($urandom);
                        dp_d.push_back(ck_pixel);
                    end
                end else if (noise && (win_req || pif.pix_valid || ck_clear)) begin
                    ck_done = 1'($urandom);
                end
                if (ck_start) begin
                    if (prev_start) start_bad++;
                    start_cyc.push_back(cyc);
                    dp_cnt = dp_lat;
                end
                prev_start = ck_start;

                if (win_req) begin
                    if (wcnt > 0 && (win_x != lw_x || win_y != lw_y)) stab_bad++;
                    lw_x = win_x;
                    lw_y = win_y;
                    win_ready = (wcnt >= win_delay);
                    wcnt++;
                end else begin
                    wcnt = 0;
                    win_ready = noise ? 1'($urandom) : 1'b0;
                end

                if (pif.pix_valid) begin
                    if (pcnt > 0 && (pif.pix_data != lp_d ||
                        pif.pix_x != lp_x || pif.pix_y != lp_y)) stab_bad++;
                    lp_d = pif.pix_data;
                    lp_x = pif.pix_x;
                    lp_y = pif.pix_y;
                    pif.pix_ready = (pcnt >= pix_delay);
                    if (pif.pix_ready) begin
                        obs_x.push_back(int'(pif.pix_x));
                        obs_y.push_back(int'(pif.pix_y));
                        obs_d.push_back(pif.pix_data);
                    end else begin
                        stall_obs++;
                    end
                    pcnt++;
                end else begin
                    pcnt = 0;
                    pif.pix_ready = noise ? 1'($urandom) : 1'b0;
                end

                if (ck_clear) begin
                    clr_hi_cur++;
                    if (clr_hi_cur > clr_hi_max) clr_hi_max = clr_hi_cur;
                    ck_clear_flag = (ccnt >= clr_delay);
                    ccnt++;
                end else begin
                    ccnt = 0;
                    clr_hi_cur = 0;
                    ck_clear_flag = noise ? 1'($urandom) : 1'b0;
                end

                if (win_req && ck_clear) win_in_clear++;
                if (frame_done) n_done++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        obs_x.delete();
        obs_y.delete();
        obs_d.delete();
        dp_d.delete();
        start_cyc.delete();
        n_done = 0;
        stab_bad = 0;
        start_bad = 0;
        win_in_clear = 0;
        stall_obs = 0;
        clr_hi_max = 0;
    endtask

    // Raster-order reference: pixel i must be (x,y) of the i-th loop step
    // and carry the i-th value the datapath model produced.
    function automatic int frame_errs(input int lx, input int ly);
        int e;
        int i;
        int n;
        e = 0;
        i = 0;
        n = (lx + 1) * (ly + 1);
        if (obs_d.size() != n || dp_d.size() != n) return 1000 + obs_d.size();
        for (int yy = 0; yy <= ly; yy++) begin
            for (int xx = 0; xx <= lx; xx++) begin
                if (obs_x[i] != xx || obs_y[i] != yy || obs_d[i] !== dp_d[i]) e++;
                i++;
            end
        end
        return e;
    endfunction

    task automatic run_frame(input int lx, input int ly, input int ks,
                             input int mid_at, output bit to);
        bit seen;
        seen = 0;
        clear_stats();
        @(negedge clk);
        cfg_last_x = 6'(lx);
        cfg_last_y = 6'(ly);
        cfg_ksize = 2'(ks);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        cfg_last_x = 6'($urandom);
        cfg_last_y = 6'($urandom);
        cfg_ksize = 2'($urandom);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (k == mid_at) begin
                cfg_last_x = 6'd5;
                cfg_ksize = 2'(~ks);
                frame_start = 1;
            end else begin
                frame_start = 0;
            end
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        frame_start = 0;
        repeat (4) @(negedge clk);
        to = !seen;
    endtask

    task automatic test_reset();
        n_rst = 1;
        frame_start = 0;
        cfg_last_x = 0;
        cfg_last_y = 0;
        cfg_ksize = 0;
        win_ready = 0;
        ck_done = 0;
        ck_pixel = 0;
        ck_clear_flag = 0;
        pif.pix_ready = 0;
        #2 n_rst = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({win_req, win_x, win_y, ck_start, ck_clear, pif.pix_valid,
             pif.pix_data, pif.pix_x, pif.pix_y, busy, frame_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        checks++;
        if (ck_ksize !== 2'd0) begin
            failures++;
            $display("FAIL reset_ksize: got %0d required 0", ck_ksize);
        end
        n_rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || win_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%0b win_req=%0b required 0 0", busy, win_req);
        end
    endtask

    task automatic test_basic();
        bit to;
        int bad;
        win_delay = 0; pix_delay = 0; clr_delay = 0; dp_lat = 3;
        noise = 0; force_pix = 0;
        run_frame(1, 1, 2, -1, to);
        checks++;
        if (to !== 1'b0) begin
            failures++;
            $display("FAIL basic_timeout: frame_done not seen");
        end
        checks++;
        if (frame_errs(1, 1) != 0) begin
            failures++;
            $display("FAIL basic_order: %0d errors, required 0", frame_errs(1, 1));
        end
        checks++;
        if (n_done != 1) begin
            failures++;
            $display("FAIL basic_done: got %0d pulses required 1", n_done);
        end
        bad = 0;
        if (start_cyc.size() != 4) bad = 100;
        else for (int i = 1; i < 4; i++)
            if (start_cyc[i] - start_cyc[i-1] != 5 + dp_lat) bad++;
        checks++;
        if (bad != 0 || start_bad != 0) begin
            failures++;
            $display("FAIL basic_latency: %0d bad spacings, required period %0d",
                     bad, 5 + dp_lat);
        end
        checks++;
        if (ck_ksize !== 2'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_cfg: ksize=%0d busy=%0b required 2 0", ck_ksize, busy);
        end
    endtask

    task automatic test_stall();
        bit to;
        pix_delay = 10; dp_lat = 2;
        run_frame(0, 0, 1, -1, to);
        checks++;
        if (to || frame_errs(0, 0) != 0 || stab_bad != 0) begin
            failures++;
            $display("FAIL stall_stable: to=%0b errs=%0d unstable=%0d required 0",
                     to, frame_errs(0, 0), stab_bad);
        end
        checks++;
        if (stall_obs != 10) begin
            failures++;
            $display("FAIL stall_cycles: got %0d required 10", stall_obs);
        end
`ifdef SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd10) begin
            failures++;
            $display("FAIL stall_cnt: got %0d required 10", stall_cnt);
        end
`endif
        pix_delay = 0;
    endtask

    task automatic test_mid_frame();
        bit to;
        dp_lat = 3;
        run_frame(1, 1, 1, 6, to);
        checks++;
        if (to || frame_errs(1, 1) != 0) begin
            failures++;
            $display("FAIL mid_dims: to=%0b errs=%0d required 0", to, frame_errs(1, 1));
        end
        checks++;
        if (ck_ksize !== 2'd1 || n_done != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_cfg: ksize=%0d done=%0d busy=%0b required 1 1 0",
                     ck_ksize, n_done, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit got;
        dp_lat = 20;
        clear_stats();
        @(negedge clk);
        cfg_last_x = 3;
        cfg_last_y = 0;
        cfg_ksize = 3;
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ck_start) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rstmid_start: ck_start not seen");
        end
        repeat (5) @(negedge clk);
        #2 n_rst = 0;
        #1;
        checks++;
        if ({win_req, ck_start, ck_clear, ck_ksize, pif.pix_valid, pif.pix_data,
             pif.pix_x, pif.pix_y, win_x, win_y, busy, frame_done} !== '0) begin
            failures++;
            $display("FAIL rstmid_async: outputs nonzero, required all 0");
        end
        repeat (2) @(negedge clk);
        n_rst = 1;
        repeat (30) @(negedge clk);
        checks++;
        if (n_done != 0 || busy !== 1'b0 || obs_d.size() != 0) begin
            failures++;
            $display("FAIL rstmid_idle: done=%0d busy=%0b pix=%0d required 0 0 0",
                     n_done, busy, obs_d.size());
        end
        dp_lat = 1;
        run_frame(0, 0, 0, -1, to);
        checks++;
        if (to || frame_errs(0, 0) != 0) begin
            failures++;
            $display("FAIL rstmid_recover: to=%0b errs=%0d required 0",
                     to, frame_errs(0, 0));
        end
    endtask

    task automatic test_single();
        bit to;
        force_pix = 1;
        dp_lat = 2;
        run_frame(0, 0, 0, -1, to);
        checks++;
        if (to || obs_d.size() != 1 || start_cyc.size() != 1 || n_done != 1) begin
            failures++;
            $display("FAIL single_counts: to=%0b pix=%0d starts=%0d done=%0d required 0 1 1 1",
                     to, obs_d.size(), start_cyc.size(), n_done);
        end else begin
            checks++;
            if (obs_d[0] !== 8'hA5 || obs_x[0] != 0 || obs_y[0] != 0) begin
                failures++;
                $display("FAIL single_pixel: got %h at (%0d,%0d) required a5 at (0,0)",
                         obs_d[0], obs_x[0], obs_y[0]);
            end
        end
        force_pix = 0;
    endtask

    task automatic test_clear_delay();
        bit to;
        clr_delay = 3;
        dp_lat = 1;
        run_frame(1, 0, 2, -1, to);
        checks++;
        if (clr_hi_max != 4) begin
            failures++;
            $display("FAIL clear_hold: held %0d cycles required 4", clr_hi_max);
        end
        checks++;
        if (to || win_in_clear != 0 || frame_errs(1, 0) != 0) begin
            failures++;
            $display("FAIL clear_order: to=%0b overlap=%0d errs=%0d required 0",
                     to, win_in_clear, frame_errs(1, 0));
        end
        clr_delay = 0;
    endtask

    task automatic test_random();
        bit to;
        int lx, ly;
        noise = 1;
        for (int r = 0; r < 8; r++) begin
            lx = $urandom_range(0, 3);
            ly = $urandom_range(0, 3);
            win_delay = $urandom_range(0, 3);
            pix_delay = $urandom_range(0, 3);
            clr_delay = $urandom_range(0, 3);
            dp_lat = $urandom_range(1, 4);
            run_frame(lx, ly, r % 4, -1, to);
            checks++;
            if (to || frame_errs(lx, ly) != 0 || stab_bad != 0) begin
                failures++;
                $display("FAIL random_frame%0d: to=%0b errs=%0d unstable=%0d required 0",
                         r, to, frame_errs(lx, ly), stab_bad);
            end
            checks++;
            if (n_done != 1 || start_cyc.size() != (lx + 1) * (ly + 1) ||
                start_bad != 0 || ck_ksize !== 2'(r % 4)) begin
                failures++;
                $display("FAIL random_ctl%0d: done=%0d starts=%0d ksize=%0d required 1 %0d %0d",
                         r, n_done, start_cyc.size(), ck_ksize, (lx + 1) * (ly + 1), r % 4);
            end
        end
        noise = 0;
        win_delay = 0;
        pix_delay = 0;
        clr_delay = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_mid_frame();
        test_reset_mid();
        test_single();
        test_clear_delay();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
